// File: rtl/dffce_arb_pkg.sv
// Shared types and elaboration helpers for the DFFCE round-robin arbiter.
package dffce_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  localparam int MAX_REQ = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // OR-reduction of set-bit positions; exact for one-hot or all-zero input.
  function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) r = r | i;
    end
    return r;
  endfunction

endpackage

// File: rtl/dffce_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr_i, wrapping.
module dffce_rr_pick
  import dffce_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic               valid_o,
  output logic [IW-1:0]      idx_o
);

  logic [NUM_REQ-1:0] win;
  logic [MAX_REQ-1:0] win_ext;
  logic [IW-1:0]      scan_idx;
  logic               found;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    win      = '0;
    found    = 1'b0;
    scan_idx = ptr_i;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = IW'((int'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[scan_idx]) begin
        win[scan_idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  always_comb begin
    win_ext              = '0;
    win_ext[NUM_REQ-1:0] = win;
  end

  assign valid_o = found;
  assign idx_o   = IW'(onehot_to_idx(win_ext));

endmodule

// File: rtl/dffce_rr_arbiter.sv
// Round-robin owner arbitration in front of one shared CLEAR/CE/D/Q register.
// Optional grant watchdog and WDOG_FIRE port: define DFFCE_RR_ARBITER_WATCHDOG_EN.
module dffce_rr_arbiter
  import dffce_arb_pkg::*;
#(
  parameter int               NUM_REQ  = 4,
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] INIT     = {WIDTH{1'b0}},
  parameter int               MAX_HOLD = 16
) (
  input  logic                      CLK,
  input  logic                      CLEAR,
  input  logic [NUM_REQ-1:0]        REQ,
  input  logic [NUM_REQ-1:0]        WE,
  input  logic [NUM_REQ*WIDTH-1:0]  D,
  output logic [NUM_REQ-1:0]        GNT,
  output logic [clog2(NUM_REQ)-1:0] OWNER,
  output logic                      BUSY,
  output logic                      CE,
  output logic [WIDTH-1:0]          Q
`ifdef DFFCE_RR_ARBITER_WATCHDOG_EN
  ,
  output logic                      WDOG_FIRE
`endif
);

  localparam int IW = clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || MAX_HOLD < 2) begin : g_bad_param
    $error("dffce_rr_arbiter: NUM_REQ must be 2..16 and MAX_HOLD >= 2");
  end

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  // Holds Q ^ INIT, so a register that powers up at zero presents INIT until the first CLEAR.
  logic [WIDTH-1:0]   qx_q, qx_d;

  logic [WIDTH-1:0]   d_slice [NUM_REQ];
  logic [NUM_REQ-1:0] pick_req;
  logic               pick_valid;
  logic [IW-1:0]      pick_idx;
  logic               owner_req;
  logic               wdog_force;
  logic               grant_new;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign d_slice[i] = D[i*WIDTH +: WIDTH];
  end

  assign owner_req = REQ[owner_q];
  assign BUSY      = |gnt_q;
  assign CE        = BUSY & owner_req & WE[owner_q] & ~wdog_force;
  assign pick_req  = (state_q == OWNED) ? (REQ & ~gnt_q) : REQ;

  dffce_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req_i   (pick_req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

`ifdef DFFCE_RR_ARBITER_WATCHDOG_EN
  localparam int HW = clog2(MAX_HOLD);

  logic [HW-1:0] hold_q, hold_d;
  logic          wdog_q;
  logic          hold_last;

  assign hold_last  = (hold_q == HW'(MAX_HOLD - 1));
  assign wdog_force = (state_q == OWNED) && owner_req && hold_last && (|(REQ & ~gnt_q));
  assign WDOG_FIRE  = wdog_q;

  always_comb begin
    hold_d = hold_q;
    if (grant_new) begin
      hold_d = '0;
    end else if (state_q == OWNED && !hold_last) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge CLEAR) begin
    if (CLEAR) begin
      hold_q <= '0;
      wdog_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      wdog_q <= wdog_force;
    end
  end
`else
  assign wdog_force = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    grant_new = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) grant_new = 1'b1;
      end
      OWNED: begin
        if (!owner_req || wdog_force) begin
          if (pick_valid) begin
            grant_new = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
    endcase
    if (grant_new) begin
      state_d           = OWNED;
      gnt_d             = '0;
      gnt_d[pick_idx]   = 1'b1;
      owner_d           = pick_idx;
      ptr_d             = pick_idx;
    end
  end

  assign qx_d = CE ? (d_slice[owner_q] ^ INIT) : qx_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge CLEAR) begin
    if (CLEAR) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
      qx_q    <= INIT;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      qx_q    <= qx_d;
    end
  end

  assign GNT   = gnt_q;
  assign OWNER = owner_q;
  assign Q     = qx_q ^ INIT;

endmodule

// File: tb/tb_dffce_rr_arbiter.sv
// Scoreboard bench for dffce_rr_arbiter: driver queues expectations, negedge monitor compares.
module tb_dffce_rr_arbiter;

  typedef struct packed {
    logic       q_only;
    logic [3:0] gnt;
    logic       own_vld;
    logic [1:0] own;
    logic       busy;
    logic       ce;
    logic [7:0] q;
    logic       wd;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    chk_cnt  = 0;
  int    pass_cnt = 0;

  logic        CLK;
  logic        CLEAR;
  logic [3:0]  REQ;
  logic [3:0]  WE;
  logic [31:0] D;
  logic [3:0]  GNT;
  logic [1:0]  OWNER;
  logic        BUSY;
  logic        CE;
  logic [7:0]  Q;
`ifdef DFFCE_RR_ARBITER_WATCHDOG_EN
  logic        WDOG_FIRE;
`endif

  dffce_rr_arbiter #(
    .NUM_REQ  (4),
    .WIDTH    (8),
    .INIT     (8'h5A),
    .MAX_HOLD (4)
  ) dut (
    .CLK       (CLK),
    .CLEAR     (CLEAR),
    .REQ       (REQ),
    .WE        (WE),
    .D         (D),
    .GNT       (GNT),
    .OWNER     (OWNER),
    .BUSY      (BUSY),
    .CE        (CE),
    .Q         (Q)
`ifdef DFFCE_RR_ARBITER_WATCHDOG_EN
    ,
    .WDOG_FIRE (WDOG_FIRE)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  exp_t  m_e;
  string m_nm;
  logic  m_ok;
  logic  m_wd;

  initial begin
    forever begin
      @(negedge CLK);
      if (exp_q.size() != 0) begin
        m_e  = exp_q.pop_front();
        m_nm = name_q.pop_front();
        m_wd = 1'b0;
`ifdef DFFCE_RR_ARBITER_WATCHDOG_EN
        m_wd = WDOG_FIRE;
`endif
        if (m_e.q_only) begin
          m_ok = (Q == m_e.q);
        end else begin
          m_ok = (GNT == m_e.gnt) && (!m_e.own_vld || OWNER == m_e.own) &&
                 (BUSY == m_e.busy) && (CE == m_e.ce) && (Q == m_e.q) && (m_wd == m_e.wd);
        end
        chk_cnt++;
        if (m_ok) begin
          pass_cnt++;
        end else begin
          $display("FAIL %s: got gnt=%b owner=%0d busy=%b ce=%b q=%h wdog=%b, want gnt=%b owner=%0d(chk=%b) busy=%b ce=%b q=%h wdog=%b",
                   m_nm, GNT, OWNER, BUSY, CE, Q, m_wd,
                   m_e.gnt, m_e.own, m_e.own_vld, m_e.busy, m_e.ce, m_e.q, m_e.wd);
        end
      end
    end
  end

  task automatic push_exp(input exp_t e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // One cycle: drive inputs just after the edge and queue what the DUT must show this cycle.
  task automatic cyc(input logic clr, input logic [3:0] req, input logic [3:0] we,
                     input logic [31:0] d, input logic [3:0] e_gnt, input logic e_own_vld,
                     input logic [1:0] e_own, input logic e_ce, input logic [7:0] e_q,
                     input logic e_wd, input string nm);
    exp_t e;
    @(posedge CLK);
    #1;
    CLEAR = clr;
    REQ   = req;
    WE    = we;
    D     = d;
    e.q_only  = 1'b0;
    e.gnt     = e_gnt;
    e.own_vld = e_own_vld;
    e.own     = e_own;
    e.busy    = |e_gnt;
    e.ce      = e_ce;
    e.q       = e_q;
    e.wd      = e_wd;
    push_exp(e, nm);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(negedge CLK);
      #1;
    end
    if (exp_q.size() != 0) begin
      chk_cnt++;
      $display("FAIL drain_timeout: got %0d pending expectations, want 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got time %0t, want completion", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    exp_t e;
    CLEAR = 1'b0;
    REQ   = '0;
    WE    = '0;
    D     = '0;
    e       = '0;
    e.q_only = 1'b1;
    e.q      = 8'h5A;
    push_exp(e, "powerup_init");
    drain();

    CLEAR = 1'b1;
    cyc(1, 4'b0000, 4'b0000, 32'h0, 4'b0000, 1, 2'd0, 0, 8'h00, 0, "clear_active");
    @(negedge CLK);
    #1;
    CLEAR = 1'b0;

    // Handover without an idle cycle, then back to idle.
    cyc(0, 4'b0101, 4'b0000, 32'h0, 4'b0000, 1, 2'd0, 0, 8'h00, 0, "idle_before_grant");
    cyc(0, 4'b0101, 4'b0000, 32'h0, 4'b0001, 1, 2'd0, 0, 8'h00, 0, "grant_req0");
    cyc(0, 4'b0100, 4'b0000, 32'h0, 4'b0001, 1, 2'd0, 0, 8'h00, 0, "hold_req0");
    cyc(0, 4'b0100, 4'b0000, 32'h0, 4'b0100, 1, 2'd2, 0, 8'h00, 0, "handover_req2");
    cyc(0, 4'b0000, 4'b0000, 32'h0, 4'b0100, 1, 2'd2, 0, 8'h00, 0, "hold_req2");
    cyc(0, 4'b0000, 4'b0000, 32'h0, 4'b0000, 0, 2'd0, 0, 8'h00, 0, "back_to_idle");

    // Owner write vs. non-owner write, grant-edge write, write on drop.
    cyc(0, 4'b0010, 4'b1010, 32'h3C00_A500, 4'b0000, 0, 2'd0, 0, 8'h00, 0, "we_before_gnt");
    cyc(0, 4'b0010, 4'b1010, 32'h3C00_A500, 4'b0010, 1, 2'd1, 1, 8'h00, 0, "owner1_ce");
    cyc(0, 4'b0010, 4'b1000, 32'h3C00_A500, 4'b0010, 1, 2'd1, 0, 8'hA5, 0, "q_a5");
    cyc(0, 4'b0010, 4'b1000, 32'h3C00_7700, 4'b0010, 1, 2'd1, 0, 8'hA5, 0, "nonowner_we_ignored");
    cyc(0, 4'b0000, 4'b0010, 32'h0000_1100, 4'b0010, 1, 2'd1, 0, 8'hA5, 0, "we_on_drop_ignored");
    cyc(0, 4'b0000, 4'b0000, 32'h0, 4'b0000, 0, 2'd0, 0, 8'hA5, 0, "idle_q_kept");

    // Short CLEAR pulse between edges must reset everything by itself.
    @(negedge CLK);
    #1;
    CLEAR = 1'b1;
    #2;
    CLEAR = 1'b0;

    // Fairness: each owner drops for one cycle.
    cyc(0, 4'b1111, 4'b0000, 32'h0, 4'b0000, 1, 2'd0, 0, 8'h00, 0, "pulse_cleared");
    cyc(0, 4'b1110, 4'b0000, 32'h0, 4'b0001, 1, 2'd0, 0, 8'h00, 0, "fair_0");
    cyc(0, 4'b1101, 4'b0000, 32'h0, 4'b0010, 1, 2'd1, 0, 8'h00, 0, "fair_1");
    cyc(0, 4'b1011, 4'b0000, 32'h0, 4'b0100, 1, 2'd2, 0, 8'h00, 0, "fair_2");
    cyc(0, 4'b0111, 4'b0000, 32'h0, 4'b1000, 1, 2'd3, 0, 8'h00, 0, "fair_3");
    cyc(0, 4'b1111, 4'b0000, 32'h0, 4'b0001, 1, 2'd0, 0, 8'h00, 0, "fair_0_again");

    // CLEAR while owner 2 writes.
    cyc(0, 4'b0100, 4'b0000, 32'h0, 4'b0001, 1, 2'd0, 0, 8'h00, 0, "hold0_before_clr");
    cyc(0, 4'b0100, 4'b0100, 32'h00FF_0000, 4'b0100, 1, 2'd2, 1, 8'h00, 0, "owner2_writing");
    cyc(0, 4'b0100, 4'b0100, 32'h00FF_0000, 4'b0100, 1, 2'd2, 1, 8'hFF, 0, "owner2_wrote_ff");
    cyc(1, 4'b0100, 4'b0100, 32'h00FF_0000, 4'b0000, 1, 2'd0, 0, 8'h00, 0, "clear_async");
    cyc(1, 4'b0110, 4'b0110, 32'h00FF_FF00, 4'b0000, 1, 2'd0, 0, 8'h00, 0, "clear_write_lost");
    @(negedge CLK);
    #1;
    CLEAR = 1'b0;
    cyc(0, 4'b0110, 4'b0000, 32'h0, 4'b0010, 1, 2'd1, 0, 8'h00, 0, "restart_owner1");
    cyc(0, 4'b0000, 4'b0000, 32'h0, 4'b0010, 1, 2'd1, 0, 8'h00, 0, "hold_owner1");
    cyc(0, 4'b0000, 4'b0000, 32'h0, 4'b0000, 0, 2'd0, 0, 8'h00, 0, "final_idle");

`ifdef DFFCE_RR_ARBITER_WATCHDOG_EN
    // MAX_HOLD=4: owner 0 keeps the grant four cycles, then is rotated out.
    cyc(0, 4'b0011, 4'b0000, 32'h0, 4'b0000, 0, 2'd0, 0, 8'h00, 0, "wd_idle");
    cyc(0, 4'b0011, 4'b0000, 32'h0, 4'b0001, 1, 2'd0, 0, 8'h00, 0, "wd_hold_c0");
    cyc(0, 4'b0011, 4'b0000, 32'h0, 4'b0001, 1, 2'd0, 0, 8'h00, 0, "wd_hold_c1");
    cyc(0, 4'b0011, 4'b0001, 32'h0000_0042, 4'b0001, 1, 2'd0, 1, 8'h00, 0, "wd_hold_c2_write");
    cyc(0, 4'b0011, 4'b0001, 32'h0000_0099, 4'b0001, 1, 2'd0, 0, 8'h42, 0, "wd_ce_suppressed");
    cyc(0, 4'b0001, 4'b0000, 32'h0, 4'b0010, 1, 2'd1, 0, 8'h42, 1, "wd_fire_rotate");
    cyc(0, 4'b0001, 4'b0000, 32'h0, 4'b0001, 1, 2'd0, 0, 8'h42, 0, "wd_pulse_end");
    for (int i = 0; i < 6; i++) begin
      cyc(0, 4'b0001, 4'b0000, 32'h0, 4'b0001, 1, 2'd0, 0, 8'h42, 0, "wd_sole_kept");
    end
`endif

    drain();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
